gen_pulse_train: RTL and testbench
==================================

Name: gen_pulse_train

Overview:
Testbench stimulus stage that drives the pulse-width checker directly downstream of it. On a start request it emits a programmable train of pulses with configurable width, gap, count, initial delay and polarity. It reports busy and done status and a running pulse count, so the bench can sequence legal stimuli and deliberately narrow or wide pulses against the checker's threshold.

Parameters:
PULSE_POL, 1, active level of o_pulse (1 = high pulse, 0 = low pulse); idle level is the inverse
COUNT_WIDTH, 16, width of the width, gap and delay counters and of their config ports
NUM_WIDTH, 16, width of the pulse-count config port and of ov_pulse_cnt

Ports:
clk  input  1  clock
reset  input  1  synchronous reset, active-high
i_start  input  1  start request; sampled only in S_IDLE
i_abort  input  1  abort the current train; sampled in every state except S_IDLE
iv_delay  input  COUNT_WIDTH  idle cycles between accepted start and the first pulse
iv_pulse_width  input  COUNT_WIDTH  active cycles per pulse; 0 is treated as 1
iv_gap_width  input  COUNT_WIDTH  inactive cycles between pulses; 0 is treated as 1
iv_pulse_num  input  NUM_WIDTH  number of pulses in the train
o_pulse  output  1  generated pulse, registered
o_busy  output  1  high from the cycle after start is accepted until the train ends
o_done  output  1  one-cycle strobe at train completion or abort
ov_pulse_cnt  output  NUM_WIDTH  pulses completed in the current or last train

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state S_IDLE; o_pulse = ~PULSE_POL; o_busy = 0; o_done = 0; ov_pulse_cnt = 0; all counters 0.
- Reset wins over every other input in the same cycle. Reset during a train drives o_pulse inactive at the next edge, with no o_done.
- States: S_IDLE, S_DELAY, S_PULSE, S_GAP.
- S_IDLE:
  - i_start=1 and iv_pulse_num!=0: latch delay, width and gap (zero-substituted to 1 for width and gap) and num; clear ov_pulse_cnt; set o_busy.
  - Next state is S_DELAY if the latched delay is not 0, otherwise S_PULSE.
  - i_start=1 and iv_pulse_num==0: no state change; o_done strobes for 1 cycle on the next edge; o_busy stays 0; ov_pulse_cnt is cleared.
- Config is latched only on start. Config port changes during a train are ignored.
- Start timing: let E be the edge that accepts i_start.
  - Delay 0: o_pulse is active in the cycle after E.
  - Delay D: o_pulse is active D cycles later than that.
- S_DELAY: counts D cycles with o_pulse inactive, then moves to S_PULSE.
- S_PULSE: o_pulse is held active for exactly W cycles (W = latched width). On the edge that ends the pulse:
  - o_pulse goes inactive and ov_pulse_cnt increments.
  - If the incremented count equals num: go to S_IDLE, clear o_busy, strobe o_done in the first inactive cycle. There is no trailing gap.
  - Otherwise: go to S_GAP.
- S_GAP: o_pulse is held inactive for exactly G cycles (G = latched gap), then returns to S_PULSE. Pulses are never merged.
- i_abort=1 in S_DELAY, S_PULSE or S_GAP:
  - Next edge: S_IDLE, o_pulse inactive, o_busy=0, o_done strobes.
  - ov_pulse_cnt holds its value; a truncated pulse is not counted.
- i_abort in S_IDLE is ignored. i_start outside S_IDLE is ignored; no queuing.
- Back-to-back trains: a start asserted in the same cycle as o_done is accepted, because the state is already S_IDLE. The new train's first pulse follows with at least 1 inactive cycle.
- Counter widths:
  - Width, gap and delay counters are COUNT_WIDTH bits and count up to the latched value; maximum 2^COUNT_WIDTH-1 with no wrap.
  - ov_pulse_cnt saturates at num; it cannot exceed num.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. PULSE_POL=1, delay=0, width=5, gap=3, num=4, one-cycle start -> 4 high pulses of exactly 5 cycles separated by 3 low cycles. o_busy is high for 29 cycles. o_done strobes once in the cycle after the 4th pulse falls. ov_pulse_cnt=4.
2. PULSE_POL=0, delay=10, width=1, gap=0, num=3 -> first low pulse 11 cycles after the start edge. Pulses are 1 cycle low with 1-cycle high gaps (gap 0 treated as 1). ov_pulse_cnt=3.
3. num=0 with start -> o_pulse never active, o_busy stays 0, o_done strobes 1 cycle after start. Then start with width=0, num=1 -> a single 1-cycle pulse.
4. width=8, num=5, abort asserted in the 3rd cycle of pulse 2 -> o_pulse inactive on the next edge, o_done strobes, ov_pulse_cnt=1, no further pulses.
5. reset asserted mid-pulse of a train with num=10 -> next edge: o_pulse inactive, o_busy=0, ov_pulse_cnt=0, no o_done strobe. A start during reset is ignored.
6. Chained with the checker (LARGE1_SMALL0=0, threshold 4): train width=5, num=20 -> checker error stays 0. Then width=4 -> checker error asserts on the first pulse. A start asserted in the o_done cycle of the first train is accepted.

Source files
------------

// File: rtl/gen_pulse_train_if.sv
// Start/config/status bundle between a stimulus sequencer and gen_pulse_train.
// The master drives the train request and config; the slave (generator) drives the status outputs.
interface gen_pulse_train_if #(
  parameter int COUNT_WIDTH = 16,
  parameter int NUM_WIDTH   = 16
);
  logic                   i_start;
  logic                   i_abort;
  logic [COUNT_WIDTH-1:0] iv_delay;
  logic [COUNT_WIDTH-1:0] iv_pulse_width;
  logic [COUNT_WIDTH-1:0] iv_gap_width;
  logic [NUM_WIDTH-1:0]   iv_pulse_num;
  logic                   o_pulse;
  logic                   o_busy;
  logic                   o_done;
  logic [NUM_WIDTH-1:0]   ov_pulse_cnt;

  modport master (
    output i_start, i_abort, iv_delay, iv_pulse_width, iv_gap_width, iv_pulse_num,
    input  o_pulse, o_busy, o_done, ov_pulse_cnt
  );

  modport slave (
    input  i_start, i_abort, iv_delay, iv_pulse_width, iv_gap_width, iv_pulse_num,
    output o_pulse, o_busy, o_done, ov_pulse_cnt
  );
endinterface

// File: rtl/gen_pulse_train.sv
// Programmable pulse-train generator: optional initial delay, then num pulses of
// a fixed width separated by fixed gaps, with abort, busy/done status and a pulse count.
module gen_pulse_train #(
  parameter bit PULSE_POL   = 1'b1,
  parameter int COUNT_WIDTH = 16,
  parameter int NUM_WIDTH   = 16
) (
  input  logic            clk,
  input  logic            reset,
  gen_pulse_train_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_PULSE,
    S_GAP
  } state_t;

  localparam logic LVL_ACTIVE   = PULSE_POL;
  localparam logic LVL_INACTIVE = ~PULSE_POL;
  localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

  state_t                 state;
  logic [COUNT_WIDTH-1:0] delay_q;
  logic [COUNT_WIDTH-1:0] width_q;
  logic [COUNT_WIDTH-1:0] gap_q;
  logic [COUNT_WIDTH-1:0] timer;
  logic [NUM_WIDTH-1:0]   num_q;
  logic [NUM_WIDTH-1:0]   pulse_cnt;
  logic [NUM_WIDTH-1:0]   cnt_next;
  logic                   pulse_q;
  logic                   busy_q;
  logic                   done_q;

  assign cnt_next = pulse_cnt + 1'b1;

  // The phase timer starts at 1 on phase entry, so it never exceeds the
  // latched length and cannot wrap even at the all-ones maximum.
  // NOTE: every register here is state, so all updates use non-blocking
  // assignments; a blocking one would let later statements see the new value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      delay_q   <= '0;
      width_q   <= '0;
      gap_q     <= '0;
      timer     <= '0;
      num_q     <= '0;
      pulse_cnt <= '0;
      pulse_q   <= LVL_INACTIVE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.i_start) begin
            pulse_cnt <= '0;
            if (bus.iv_pulse_num == '0) begin
              done_q <= 1'b1;
            end else begin
              delay_q <= bus.iv_delay;
              width_q <= (bus.iv_pulse_width == '0) ? ONE : bus.iv_pulse_width;
              gap_q   <= (bus.iv_gap_width == '0) ? ONE : bus.iv_gap_width;
              num_q   <= bus.iv_pulse_num;
              timer   <= ONE;
              busy_q  <= 1'b1;
              if (bus.iv_delay == '0) begin
                state   <= S_PULSE;
                pulse_q <= LVL_ACTIVE;
              end else begin
                state <= S_DELAY;
              end
            end
          end
        end

        default: begin
          if (bus.i_abort) begin
            // A truncated pulse is deliberately left out of pulse_cnt.
            state   <= S_IDLE;
            pulse_q <= LVL_INACTIVE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            case (state)
              S_DELAY: begin
                if (timer == delay_q) begin
                  state   <= S_PULSE;
                  pulse_q <= LVL_ACTIVE;
                  timer   <= ONE;
                end else begin
                  timer <= timer + 1'b1;
                end
              end

              S_PULSE: begin
                if (timer == width_q) begin
                  pulse_q   <= LVL_INACTIVE;
                  pulse_cnt <= cnt_next;
                  timer     <= ONE;
                  if (cnt_next == num_q) begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                  end else begin
                    state <= S_GAP;
                  end
                end else begin
                  timer <= timer + 1'b1;
                end
              end

              S_GAP: begin
                if (timer == gap_q) begin
                  state   <= S_PULSE;
                  pulse_q <= LVL_ACTIVE;
                  timer   <= ONE;
                end else begin
                  timer <= timer + 1'b1;
                end
              end

              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign bus.o_pulse      = pulse_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
  assign bus.ov_pulse_cnt = pulse_cnt;

endmodule

// File: tb/tb_gen_pulse_train.sv
// Drives identical stimulus into a high-pulse and a low-pulse generator and compares
// every cycle against an arithmetic model of the expected waveform.
module tb_gen_pulse_train;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  gen_pulse_train_if #(.COUNT_WIDTH(16), .NUM_WIDTH(16)) bus1 ();
  gen_pulse_train_if #(.COUNT_WIDTH(16), .NUM_WIDTH(16)) bus0 ();

  gen_pulse_train #(.PULSE_POL(1'b1), .COUNT_WIDTH(16), .NUM_WIDTH(16)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  gen_pulse_train #(.PULSE_POL(1'b0), .COUNT_WIDTH(16), .NUM_WIDTH(16)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  typedef struct {
    bit act;
    bit busy;
    bit done;
    int cnt;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic drive(input bit start, input bit abort,
                       input int d, input int w, input int g, input int n);
    bus1.i_start = start;              bus0.i_start = start;
    bus1.i_abort = abort;              bus0.i_abort = abort;
    bus1.iv_delay = 16'(d);            bus0.iv_delay = 16'(d);
    bus1.iv_pulse_width = 16'(w);      bus0.iv_pulse_width = 16'(w);
    bus1.iv_gap_width = 16'(g);        bus0.iv_gap_width = 16'(g);
    bus1.iv_pulse_num = 16'(n);        bus0.iv_pulse_num = 16'(n);
  endtask

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int train_len(input int d, input int w, input int g, input int n);
    return (n == 0) ? 0 : d + n * eff(w) + (n - 1) * eff(g);
  endfunction

  // Pulses whose falling edge has happened before cycle k (cycle 1 follows the start edge).
  function automatic int completed(input int k, input int d, input int w, input int g);
    int p;
    int per;
    if (k <= d) return 0;
    per = eff(w) + eff(g);
    p   = k - d - 1;
    return p / per + (((p % per) >= eff(w)) ? 1 : 0);
  endfunction

  function automatic exp_t model(input int k, input int d, input int w, input int g,
                                 input int n, input int ka, input int kr);
    exp_t e;
    int   len;
    len = train_len(d, w, g, n);
    e   = '{act: 1'b0, busy: 1'b0, done: 1'b0, cnt: 0};
    if (kr > 0 && k > kr) return e;
    if (ka > 0 && k > ka) begin
      e.cnt  = completed(ka, d, w, g);
      e.done = (k == ka + 1);
      return e;
    end
    if (k <= len) begin
      e.busy = 1'b1;
      e.act  = (k > d) && (((k - d - 1) % (eff(w) + eff(g))) < eff(w));
      e.cnt  = completed(k, d, w, g);
    end else begin
      e.cnt  = n;
      e.done = (k == len + 1);
    end
    return e;
  endfunction

  // Caller is inside "cycle 0"; the start is sampled at the end of that cycle.
  // ka/kr: cycle carrying abort/reset (0 = none). chain: return in the done
  // cycle so the next call's start lands on the o_done cycle.
  task automatic run_train(input int d, input int w, input int g, input int n,
                           input int ka, input int kr, input bit chain);
    exp_t e;
    int   len;
    int   kend;
    int   busy_cycles;
    len  = train_len(d, w, g, n);
    kend = chain ? len + 1 : (ka > 0) ? ka + 3 : (kr > 0) ? kr + 3 : len + 3;
    busy_cycles = 0;
    drive(1'b1, 1'b0, d, w, g, n);
    for (int k = 1; k <= kend; k++) begin
      @(posedge clk);
      #1;
      // Config ports wander during the train; the generator must ignore them.
      drive(k == kr, k == ka, $urandom_range(0, 9), $urandom_range(0, 9),
            $urandom_range(0, 9), $urandom_range(0, 9));
      reset = (k == kr);
      @(negedge clk);
      e = model(k, d, w, g, n, ka, kr);
      check("pulse_hi", 32'(bus1.o_pulse), 32'(e.act));
      check("pulse_lo", 32'(bus0.o_pulse), 32'(!e.act));
      check("busy_hi",  32'(bus1.o_busy),  32'(e.busy));
      check("busy_lo",  32'(bus0.o_busy),  32'(e.busy));
      check("done_hi",  32'(bus1.o_done),  32'(e.done));
      check("done_lo",  32'(bus0.o_done),  32'(e.done));
      check("cnt_hi",   32'(bus1.ov_pulse_cnt), 32'(e.cnt));
      check("cnt_lo",   32'(bus0.ov_pulse_cnt), 32'(e.cnt));
      if (bus1.o_busy) busy_cycles++;
    end
    if (ka == 0 && kr == 0) check("busy_len", 32'(busy_cycles), 32'(len));
    drive(1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  initial begin
    int d, w, g, n, mode, len;
    reset = 1'b1;
    drive(1'b1, 1'b0, 0, 3, 1, 2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pulse_hi", 32'(bus1.o_pulse), 32'd0);
    check("rst_pulse_lo", 32'(bus0.o_pulse), 32'd1);
    check("rst_busy",     32'(bus1.o_busy),  32'd0);
    check("rst_done",     32'(bus1.o_done),  32'd0);
    check("rst_cnt",      32'(bus1.ov_pulse_cnt), 32'd0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    @(negedge clk);

    run_train(0, 5, 3, 4, 0, 0, 1'b0);     // basic train, busy 29 cycles
    run_train(10, 1, 0, 3, 0, 0, 1'b0);    // long delay, zero gap
    run_train(2, 3, 2, 0, 0, 0, 1'b0);     // num 0: done only
    run_train(0, 0, 4, 1, 0, 0, 1'b0);     // width 0 -> single 1-cycle pulse
    run_train(0, 8, 2, 5, 13, 0, 1'b0);    // abort in 3rd cycle of pulse 2
    run_train(2, 6, 2, 10, 0, 13, 1'b0);   // reset mid-pulse, start ignored
    run_train(0, 5, 1, 20, 0, 0, 1'b1);    // chained: next start on o_done
    run_train(0, 4, 1, 3, 0, 0, 1'b0);
    run_train(16'hffff & 3, 16'hffff, 2, 1, 0, 0, 1'b0); // maximum width

    for (int t = 0; t < 60; t++) begin
      d    = $urandom_range(0, 4);
      w    = $urandom_range(0, 5);
      g    = $urandom_range(0, 4);
      n    = $urandom_range(0, 4);
      mode = $urandom_range(0, 5);
      len  = train_len(d, w, g, n);
      if (mode == 0 && len > 0)
        run_train(d, w, g, n, $urandom_range(1, len), 0, 1'b0);
      else if (mode == 1 && len > 0)
        run_train(d, w, g, n, 0, $urandom_range(1, len), 1'b0);
      else
        run_train(d, w, g, n, 0, 0, mode == 2);
    end
    run_train(1, 2, 1, 2, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
